// File: rtl/risc16_regfile_debug_port.sv
// -----------------------------------------------------------------------------
// risc16_regfile_debug_port
//
// Debug/test initiator for the RiSC16 register file.
//   Dump: reads a range of registers through the read port (rf_addr/rf_data)
//         and streams them out on the dp_* valid/ready channel.
//   Load: takes words from the ld_* valid/ready channel and writes them through
//         the target port (rf_addrT/rf_trgt/rf_wen).
//   cpu_hold is high whenever a command is in flight; the top level muxes the
//   rf_* outputs onto the register file while it is high.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/op/start/count   command channel (op 0 = dump, 1 = load)
//   ld_valid/ready/data       load word channel (consumed in L_WAIT)
//   dp_valid/ready/data/addr/last    dump word channel
//   rf_addr, rf_data          register file read port (combinational read)
//   rf_addrT, rf_trgt, rf_wen register file write port
//   cpu_hold                  core hold, high in every state except IDLE
//   done                      one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module risc16_regfile_debug_port #(
  parameter int WORD_LENGTH  = 16,
  parameter int REG_ADDR_LEN = 3,
  parameter int REG_NUM      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [REG_ADDR_LEN-1:0] cmd_start,
  input  logic [REG_ADDR_LEN:0]   cmd_count,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [WORD_LENGTH-1:0]  ld_data,
  output logic                    dp_valid,
  input  logic                    dp_ready,
  output logic [WORD_LENGTH-1:0]  dp_data,
  output logic [REG_ADDR_LEN-1:0] dp_addr,
  output logic                    dp_last,
  output logic [REG_ADDR_LEN-1:0] rf_addr,
  input  logic [WORD_LENGTH-1:0]  rf_data,
  output logic [REG_ADDR_LEN-1:0] rf_addrT,
  output logic [WORD_LENGTH-1:0]  rf_trgt,
  output logic                    rf_wen,
  output logic                    cpu_hold,
  output logic                    done
);

  localparam logic [REG_ADDR_LEN:0]   REM_MAX   = (REG_ADDR_LEN+1)'(REG_NUM);
  localparam logic [REG_ADDR_LEN:0]   REM_ONE   = (REG_ADDR_LEN+1)'(1);
  localparam logic [REG_ADDR_LEN-1:0] LAST_ADDR = REG_ADDR_LEN'(REG_NUM - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_FETCH = 3'd1,
    D_SEND  = 3'd2,
    L_WAIT  = 3'd3,
    L_WRITE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [REG_ADDR_LEN-1:0] cur;
  logic [REG_ADDR_LEN:0]   rem;

  // A command never touches more registers than the file holds.
  function automatic logic [REG_ADDR_LEN:0] clamp_count(input logic [REG_ADDR_LEN:0] c);
    return (c > REM_MAX) ? REM_MAX : c;
  endfunction

  // Address increment wrapping REG_NUM-1 -> 0 (REG_NUM need not be a power of two).
  function automatic logic [REG_ADDR_LEN-1:0] next_addr(input logic [REG_ADDR_LEN-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // The read port always points at the current register; it only matters in D_FETCH.
  assign rf_addr = cur;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    rf_wen    = 1'b0;
    done      = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        cpu_hold  = 1'b0;
        if (cmd_valid) begin
          if (cmd_count == '0)  state_nxt = DONE;
          else if (cmd_op)      state_nxt = L_WAIT;
          else                  state_nxt = D_FETCH;
        end
      end
      D_FETCH: state_nxt = D_SEND;
      D_SEND: begin
        if (dp_ready) state_nxt = (rem == REM_ONE) ? DONE : D_FETCH;
      end
      L_WAIT: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = L_WRITE;
      end
      L_WRITE: begin
        // r0 is hardwired zero: the word is consumed but never written.
        rf_wen    = (rf_addrT != '0);
        state_nxt = (rem == REM_ONE) ? DONE : L_WAIT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      rem      <= '0;
      dp_valid <= 1'b0;
      dp_data  <= '0;
      dp_addr  <= '0;
      dp_last  <= 1'b0;
      rf_addrT <= '0;
      rf_trgt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur <= cmd_start;
            rem <= clamp_count(cmd_count);
          end
        end
        D_FETCH: begin
          dp_data  <= rf_data;
          dp_addr  <= cur;
          dp_last  <= (rem == REM_ONE);
          dp_valid <= 1'b1;
        end
        D_SEND: begin
          if (dp_ready) begin
            dp_valid <= 1'b0;
            rem      <= rem - 1'b1;
            cur      <= next_addr(cur);
          end
        end
        L_WAIT: begin
          if (ld_valid) begin
            rf_addrT <= cur;
            rf_trgt  <= ld_data;
          end
        end
        L_WRITE: begin
          rem <= rem - 1'b1;
          cur <= next_addr(cur);
        end
        default: ;
      endcase
    end
  end

endmodule
